// File: rtl/keypad_scan_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : keypad_scan_debounce                                            |
// | Scans a 4x4 active-low matrix keypad, debounces whole frames and emits   |
// | one key_valid strobe with the decoded key code per accepted press.       |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module keypad_scan_debounce #(
    parameter int SCAN_DIV       = 10,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] kb_row_n,
    output logic [3:0] kb_col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [1:0] scan_state
);

    localparam logic [1:0] c_st_scan     = 2'd0;
    localparam logic [1:0] c_st_debounce = 2'd1;
    localparam logic [1:0] c_st_held     = 2'd2;
    localparam logic [7:0] c_div_last    = 8'(SCAN_DIV - 1);
    localparam logic [3:0] c_db_target   = 4'(DEBOUNCE_SCANS);

    logic [3:0]  r_row_meta, r_row_sync;
    logic [7:0]  r_div;
    logic [1:0]  r_col;
    logic        r_parked;
    logic [11:0] r_frame;
    logic [1:0]  r_state;
    logic [3:0]  r_cnt, r_rel, r_cand, r_code;
    logic        r_valid;

    logic        w_sample, w_frame_end, w_none, w_single, w_accept;
    logic [15:0] w_frame_full;
    logic [3:0]  w_idx, w_cnt_nxt, w_rel_nxt, w_cand_nxt;
    logic [1:0]  w_state_nxt;

    function automatic logic [3:0] f_key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;  4'd1:  code = 4'h4;  4'd2:  code = 4'h7;  4'd3:  code = 4'hE;
            4'd4:    code = 4'h2;  4'd5:  code = 4'h5;  4'd6:  code = 4'h8;  4'd7:  code = 4'h0;
            4'd8:    code = 4'h3;  4'd9:  code = 4'h6;  4'd10: code = 4'h9;  4'd11: code = 4'hF;
            4'd12:   code = 4'hA;  4'd13: code = 4'hB;  4'd14: code = 4'hC;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign w_sample    = !r_parked && (r_div == c_div_last);
    assign w_frame_end = w_sample && (r_col == 2'd3);
    // Column 3 is classified straight from the synchroniser on its sample cycle.
    assign w_frame_full = {~r_row_sync, r_frame};
    assign w_none       = (w_frame_full == 16'd0);
    assign w_single     = !w_none && ((w_frame_full & (w_frame_full - 16'd1)) == 16'd0);

    always_comb begin
        w_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_frame_full[i]) w_idx = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_meta <= 4'b1111;
            r_row_sync <= 4'b1111;
            r_div      <= 8'd0;
            r_col      <= 2'd0;
            r_parked   <= 1'b0;
            r_frame    <= 12'd0;
        end else begin
            r_row_meta <= kb_row_n;
            r_row_sync <= r_row_meta;
            if (!en) begin
                r_parked <= 1'b1;
                r_div    <= 8'd0;
                r_col    <= 2'd0;
                r_frame  <= 12'd0;
            end else if (r_parked) begin
                r_parked <= 1'b0;
            end else if (w_sample) begin
                r_div <= 8'd0;
                r_col <= r_col + 2'd1;
                case (r_col)
                    2'd0:    r_frame[3:0]  <= ~r_row_sync;
                    2'd1:    r_frame[7:4]  <= ~r_row_sync;
                    2'd2:    r_frame[11:8] <= ~r_row_sync;
                    default: ;
                endcase
            end else begin
                r_div <= r_div + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rel_nxt   = r_rel;
        w_cand_nxt  = r_cand;
        w_accept    = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                c_st_scan: begin
                    if (w_single) begin
                        w_cand_nxt = w_idx;
                        w_cnt_nxt  = 4'd1;
                        if (c_db_target == 4'd1) begin
                            w_state_nxt = c_st_held;
                            w_cnt_nxt   = 4'd0;
                            w_accept    = 1'b1;
                        end else begin
                            w_state_nxt = c_st_debounce;
                        end
                    end
                end
                c_st_debounce: begin
                    if (w_single && (w_idx == r_cand)) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                        if (r_cnt + 4'd1 == c_db_target) begin
                            w_state_nxt = c_st_held;
                            w_cnt_nxt   = 4'd0;
                            w_accept    = 1'b1;
                        end
                    end else begin
                        w_state_nxt = c_st_scan;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                c_st_held: begin
                    if (w_none) begin
                        w_rel_nxt = r_rel + 4'd1;
                        if (r_rel + 4'd1 == c_db_target) begin
                            w_state_nxt = c_st_scan;
                            w_rel_nxt   = 4'd0;
                        end
                    end else begin
                        w_rel_nxt = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = c_st_scan;
                    w_cnt_nxt   = 4'd0;
                    w_rel_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_scan;
            r_cnt   <= 4'd0;
            r_rel   <= 4'd0;
            r_cand  <= 4'd0;
            r_valid <= 1'b0;
            r_code  <= 4'd0;
        end else if (!en) begin
            // Parked: key_code is kept so the last digit stays readable.
            r_state <= c_st_scan;
            r_cnt   <= 4'd0;
            r_rel   <= 4'd0;
            r_cand  <= 4'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rel   <= w_rel_nxt;
            r_cand  <= w_cand_nxt;
            r_valid <= w_accept;
            if (w_accept) r_code <= f_key_map(w_cand_nxt);
        end
    end

    assign kb_col_n   = r_parked ? 4'b1111 : ~(4'b0001 << r_col);
    assign key_code   = r_code;
    assign key_valid  = r_valid;
    assign key_held   = (r_state == c_st_held);
    assign scan_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_keypad_scan_debounce                                         |
// | Directed keypad scenarios; expected strobes go through a scoreboard.     |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_keypad_scan_debounce;

    localparam int c_frame = 16;   // 4 columns x SCAN_DIV=4
    localparam int c_db    = 3;

    logic       clk = 1'b0;
    logic       reset, en;
    logic [3:0] kb_row_n, kb_col_n, key_code;
    logic       key_valid, key_held;
    logic [1:0] scan_state;

    logic [15:0] pressed;
    int          t;
    logic        running;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [3:0] code;
        int         t;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    keypad_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_SCANS(c_db)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .kb_row_n  (kb_row_n),
        .kb_col_n  (kb_col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .scan_state(scan_state)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        kb_row_n = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[4*c+r] && !kb_col_n[c]) kb_row_n[r] = 1'b0;
    end

    // Reference timebase: cycles since the scan (re)started at column 0.
    always @(posedge clk) begin
        if (reset) begin
            t <= 0; running <= 1'b1;
        end else if (!en) begin
            t <= 0; running <= 1'b0;
        end else if (!running) begin
            running <= 1'b1;
        end else begin
            t <= t + 1;
        end
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: key_code=%0h at t=%0d, required no strobe", key_code, t);
            end else begin
                mon_e = sb.pop_front();
                if (key_code !== mon_e.code || t != mon_e.t || key_held !== 1'b1) begin
                    errors++;
                    $display("FAIL strobe: code=%0h t=%0d held=%0b, required code=%0h t=%0d held=1",
                             key_code, t, key_held, mon_e.code, mon_e.t);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (c_frame * n) @(negedge clk);
    endtask

    task automatic expect_press(input logic [3:0] code);
        exp_t e;
        e.code = code;
        e.t    = t + c_frame * c_db;
        sb.push_back(e);
    endtask

    initial begin
        logic [3:0] exp_col;
        reset = 1'b1; en = 1'b1; pressed = 16'd0;
        repeat (2) @(negedge clk);
        check("reset_col",   32'(kb_col_n),   32'hE);
        check("reset_code",  32'(key_code),   32'h0);
        check("reset_valid", 32'(key_valid),  32'h0);
        check("reset_held",  32'(key_held),   32'h0);
        check("reset_state", 32'(scan_state), 32'h0);
        reset = 1'b0;

        for (int c = 0; c < 4; c++) begin
            exp_col = ~(4'b0001 << c);
            check("scan_col", 32'(kb_col_n), 32'(exp_col));
            repeat (4) @(negedge clk);
        end
        frames(9);

        // Clean press of '5' (row1/col1), then long hold without repeat.
        pressed[5] = 1'b1;
        expect_press(4'h5);
        frames(c_db);
        check("press5_held",  32'(key_held),   32'h1);
        check("press5_state", 32'(scan_state), 32'h2);
        @(negedge clk);
        check("press5_pulse_len", 32'(key_valid), 32'h0);
        repeat (c_frame * 20 - 1) @(negedge clk);
        pressed = 16'd0;
        frames(c_db);
        check("release5_held", 32'(key_held), 32'h0);

        // Bouncing '*' never stays stable long enough, then settles.
        repeat (3) begin
            pressed[3] = 1'b1; frames(2);
            pressed[3] = 1'b0; frames(1);
        end
        check("bounce_state", 32'(scan_state), 32'h0);
        pressed[3] = 1'b1;
        expect_press(4'hE);
        frames(c_db);
        check("bounce_code", 32'(key_code), 32'hE);
        pressed = 16'd0;
        frames(c_db);

        // Two keys together are rejected; the survivor is accepted.
        pressed[0] = 1'b1; pressed[10] = 1'b1;
        frames(6);
        check("multi_held", 32'(key_held), 32'h0);
        pressed[0] = 1'b0;
        expect_press(4'h9);
        frames(c_db);
        check("multi_code", 32'(key_code), 32'h9);
        pressed = 16'd0;
        frames(c_db);

        // Short release of '2' is absorbed; a full release allows a new strobe.
        pressed[4] = 1'b1;
        expect_press(4'h2);
        frames(c_db);
        pressed[4] = 1'b0; frames(2);
        pressed[4] = 1'b1; frames(2);
        check("short_release_held", 32'(key_held), 32'h1);
        pressed[4] = 1'b0; frames(c_db);
        check("full_release_held", 32'(key_held), 32'h0);
        check("code_kept", 32'(key_code), 32'h2);
        pressed[4] = 1'b1;
        expect_press(4'h2);
        frames(c_db);
        check("repress_held", 32'(key_held), 32'h1);
        pressed = 16'd0;
        frames(c_db);

        // Enable dropped mid-debounce discards the candidate.
        pressed[15] = 1'b1;
        frames(1);
        check("en_pre_state", 32'(scan_state), 32'h1);
        repeat (8) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en_low_col",   32'(kb_col_n),   32'hF);
        check("en_low_state", 32'(scan_state), 32'h0);
        check("en_low_code",  32'(key_code),   32'h2);
        repeat (4) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("en_restart_col", 32'(kb_col_n), 32'hE);
        expect_press(4'hD);
        frames(c_db);
        check("en_redebounce_code", 32'(key_code), 32'hD);

        // Reset while held.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_held",  32'(key_held),   32'h0);
        check("midreset_code",  32'(key_code),   32'h0);
        check("midreset_state", 32'(scan_state), 32'h0);
        check("midreset_col",   32'(kb_col_n),   32'hE);
        reset = 1'b0;
        pressed = 16'd0;
        frames(4);

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
